down_counter_nbit: RTL
======================

// Module: down_counter_nbit
// PURPOSE
//   Loadable WIDTH-bit down counter: the decrementing counterpart of the team's up counters.
//   Used for countdowns: timeouts, beat/burst length tracking, stall-cycle budgets.
//   Supports a parallel load, a synchronous clear and a terminal-count flag.
//   Reports an underflow pulse and flags undefined control inputs.
// PARAMETERS
//   WIDTH  4  counter width in bits; legal range 2..16
// PORTS
//   clk      in   1      clock; all state updates on the rising edge
//   rst      in   1      reset; synchronous, active-high; overrides every other input
//   ctr_rst  in   1      synchronous clear of the count
//   ld       in   1      parallel load strobe
//   ld_val   in   WIDTH  value captured when ld=1
//   ctr_en   in   1      decrement enable
//   out      out  WIDTH  current count (registered)
//   tc       out  1      terminal count; combinational, tc = (out == 0)
//   uflow    out  1      registered one-cycle pulse: a decrement from 0 occurred last cycle
//   err      out  1      combinational; 1 when ctr_rst/ld/ctr_en is X/Z
// BEHAVIOUR
//   Reset (rst=1 at edge):
//     - out=0 and uflow=0; tc=1 follows from out=0.
//     - Reload register is set to all-ones (only when DOWN_CTR_AUTORELOAD_EN is defined).
//   Priority per edge: rst > ctr_rst > ld > ctr_en > hold.
//     - ctr_rst=1: out<=0; uflow<=0.
//     - ld=1: out<=ld_val; uflow<=0; ctr_en is ignored that cycle.
//     - ctr_en=1 and out!=0: out<=out-1; uflow<=0.
//     - ctr_en=1 and out==0: underflow; next value per CONFIGURATION; uflow<=1.
//     - otherwise: out holds; uflow<=0.
//   Latency:
//     - out changes one edge after the controlling input is sampled.
//     - tc follows out in the same cycle.
//     - uflow is high for exactly the cycle after the underflowing edge.
//   Arithmetic: unsigned modulo-2^WIDTH; no carry-out other than uflow.
//   Back-to-back underflows: uflow stays high for consecutive cycles, one per underflowing edge.
//   err:
//     - Asserted combinationally while any of ctr_rst/ld/ctr_en is X/Z.
//     - While err=1, out and uflow hold their values (no X propagation into state).
//     - rst is not masked by err.
//   rst asserted mid-count: the count is discarded; no uflow is generated.
// CONFIGURATION
//   Macro DOWN_CTR_AUTORELOAD_EN:
//     - Undefined: underflow wraps out to {WIDTH{1'b1}}.
//     - Defined: adds a WIDTH-bit reload register, written with ld_val whenever ld=1 takes effect.
//       Underflow sets out to the reload value; ctr_rst does not clear the reload register.
// STRUCTURE
//   Shared constants file (down_ctr_defs.vh):
//     - default WIDTH;
//     - priority encoding of {ctr_rst,ld,ctr_en} used in the casex.
//   State registers are built from arrays of the existing dff cell.
//   One sub-module: down_ctr_next (combinational next-count/uflow/err logic),
//   so the same logic can be reused by a future up/down counter.
// TESTING
//   1. rst=1 for 2 cycles -> out=0, tc=1, uflow=0, err=0.
//   2. ld=1, ld_val=4'h5, then ctr_en=1 for 5 cycles -> out 5,4,3,2,1,0; tc=1 on the 0 cycle only.
//   3. out=0, ctr_en=1 -> out=4'hF (macro undefined) or last ld_val (macro defined);
//      uflow=1 for exactly one cycle.
//   4. ld=1, ctr_rst=1, ctr_en=1 together with out=7 -> out=0 (clear wins).
//      Then ld=1, ctr_en=1 with ld_val=9 -> out=9 (load wins over decrement).
//   5. ctr_en=1'bx while out=3 -> err=1; out stays 3 and uflow stays 0 for that cycle.
//   6. rst=1 asserted while counting down from 4'hA -> out=0 next edge; reload register=4'hF
//      (macro defined); a subsequent underflow yields out=4'hF.

Source files
------------

// File: rtl/down_counter_nbit_pkg.sv
// rtl/down_counter_nbit_pkg.sv - shared constants and control decode for the down counter
//
// Purpose:
//    Default width and the priority decode of {ctr_rst, ld, ctr_en}.
//    Imported by down_counter_nbit and down_counter_nbit_next.
// Ports: none (package).
// Configuration macro: DOWN_CTR_AUTORELOAD_EN (consumed by the top, not here).

package down_counter_nbit_pkg;

   localparam int DEFAULT_WIDTH = 4;
   localparam int MIN_WIDTH     = 2;
   localparam int MAX_WIDTH     = 16;

   // Operation selected for one clock edge, after priority resolution.
   typedef enum logic [2:0] {
      OP_HOLD  = 3'd0,
      OP_CLR   = 3'd1,
      OP_LOAD  = 3'd2,
      OP_DEC   = 3'd3,
      OP_UFLOW = 3'd4
   } op_e;

   // Priority: ctr_rst > ld > ctr_en > hold. Underflow is resolved by the
   // caller because it depends on the current count.
   function automatic op_e ctl_decode(input logic ctr_rst,
                                      input logic ld,
                                      input logic ctr_en);
      op_e op;
      casez ({ctr_rst, ld, ctr_en})
         3'b1??:  op = OP_CLR;
         3'b01?:  op = OP_LOAD;
         3'b001:  op = OP_DEC;
         default: op = OP_HOLD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/down_counter_nbit_next.sv
// rtl/down_counter_nbit_next.sv - combinational next-count, underflow and err logic
//
// Purpose:
//    Computes the next count and next uflow from the current state and the
//    control inputs. Kept separate so an up/down counter can reuse it.
// Ports:
//    cur_count   in   WIDTH  current registered count
//    cur_uflow   in   1      current registered uflow (held while err=1)
//    ld_val      in   WIDTH  parallel load value
//    reload_val  in   WIDTH  value taken on underflow
//    ctr_rst     in   1      synchronous clear request
//    ld          in   1      load request
//    ctr_en      in   1      decrement request
//    next_count  out  WIDTH  count to register at the next edge
//    next_uflow  out  1      uflow to register at the next edge
//    load_taken  out  1      a load takes effect this edge
//    err         out  1      a control input is X/Z
// Configuration macro: DOWN_CTR_AUTORELOAD_EN (selects reload_val in the top).

module down_counter_nbit_next
   import down_counter_nbit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] cur_count,
   input  logic             cur_uflow,
   input  logic [WIDTH-1:0] ld_val,
   input  logic [WIDTH-1:0] reload_val,
   input  logic             ctr_rst,
   input  logic             ld,
   input  logic             ctr_en,
   output logic [WIDTH-1:0] next_count,
   output logic             next_uflow,
   output logic             load_taken,
   output logic             err
);

   op_e op;

   // XOR reduction turns any X/Z on a control input into X; in real
   // silicon this compare is constant false.
   assign err = ((^{ctr_rst, ld, ctr_en}) === 1'bx);

   always_comb begin
      op = ctl_decode(ctr_rst, ld, ctr_en);
      if (op == OP_DEC && cur_count == '0) begin
         op = OP_UFLOW;
      end
   end

   always_comb begin
      next_count = cur_count;
      next_uflow = 1'b0;
      load_taken = 1'b0;
      if (err) begin
         // Freeze state so unknown controls never reach the registers.
         next_uflow = cur_uflow;
      end else begin
         case (op)
            OP_CLR:   next_count = '0;
            OP_LOAD: begin
               next_count = ld_val;
               load_taken = 1'b1;
            end
            OP_DEC:   next_count = cur_count - 1'b1;
            OP_UFLOW: begin
               next_count = reload_val;
               next_uflow = 1'b1;
            end
            default:  next_count = cur_count;
         endcase
      end
   end

endmodule

// File: rtl/down_counter_nbit.sv
// rtl/down_counter_nbit.sv - loadable WIDTH-bit down counter with tc, uflow and err
//
// Purpose:
//    Countdown counter for timeouts, burst lengths and stall budgets.
//    Priority per edge: rst > ctr_rst > ld > ctr_en > hold.
// Ports:
//    clk      in   1      clock, rising edge
//    rst      in   1      synchronous active-high reset, overrides all inputs
//    ctr_rst  in   1      synchronous clear of the count
//    ld       in   1      parallel load strobe
//    ld_val   in   WIDTH  load value
//    ctr_en   in   1      decrement enable
//    out      out  WIDTH  registered count
//    tc       out  1      combinational, out == 0
//    uflow    out  1      registered pulse, decrement from 0 on previous edge
//    err      out  1      combinational, ctr_rst/ld/ctr_en is X/Z
// Configuration macro:
//    DOWN_CTR_AUTORELOAD_EN  defined: underflow reloads the last loaded value
//                            undefined: underflow wraps to all-ones

module down_counter_nbit
   import down_counter_nbit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ctr_rst,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             ctr_en,
   output logic [WIDTH-1:0] out,
   output logic             tc,
   output logic             uflow,
   output logic             err
);

   logic [WIDTH-1:0] next_count;
   logic             next_uflow;
   logic             load_taken;
   logic [WIDTH-1:0] reload_val;

`ifdef DOWN_CTR_AUTORELOAD_EN
   logic [WIDTH-1:0] reload_q;

   // Reload value survives ctr_rst; only rst returns it to all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         reload_q <= '1;
      end else if (load_taken) begin
         reload_q <= ld_val;
      end
   end

   assign reload_val = reload_q;
`else
   assign reload_val = '1;
`endif

   down_counter_nbit_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .cur_count  (out),
      .cur_uflow  (uflow),
      .ld_val     (ld_val),
      .reload_val (reload_val),
      .ctr_rst    (ctr_rst),
      .ld         (ld),
      .ctr_en     (ctr_en),
      .next_count (next_count),
      .next_uflow (next_uflow),
      .load_taken (load_taken),
      .err        (err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         out   <= '0;
         uflow <= 1'b0;
      end else begin
         out   <= next_count;
         uflow <= next_uflow;
      end
   end

   assign tc = (out == '0);

endmodule
